// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce.
// Drives one active-low column at a time, samples the registered rows at the
// last cycle of each column period, and presents a held-level key strobe.
// Optional build macro: KEYPAD_ROW_SYNC_EN adds a metastability flop ahead of
// rows_q for asynchronous keypad pins.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       readKey,
  output logic [3:0] pressedkey
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TGT  = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_SCAN     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_ASSERT   = 2'd2;
  localparam logic [1:0] S_HELD     = 2'd3;

  logic [1:0]       state;
  logic [1:0]       col;
  logic [1:0]       rec_row;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] rel_cnt;
  logic [3:0]       rows_in;
  logic [3:0]       rows_q;
  logic [1:0]       low_row;
  logic             any_low;
  logic             sample;

`ifdef KEYPAD_ROW_SYNC_EN
  logic [3:0] rows_meta;

  // First synchronizer stage; rows_q acts as the second stage (2-cycle path)
  always_ff @(posedge clk) begin
    if (reset) rows_meta <= '1;
    else       rows_meta <= rows;
  end

  assign rows_in = rows_meta;
`else
  assign rows_in = rows;
`endif

  // Registered row inputs used by every sampling decision
  always_ff @(posedge clk) begin
    if (reset) rows_q <= '1;
    else       rows_q <= rows_in;
  end

  // Lowest-index low row wins (row 0 has highest priority)
  always_comb begin
    any_low = (rows_q != 4'hF);
    if (!rows_q[0])      low_row = 2'd0;
    else if (!rows_q[1]) low_row = 2'd1;
    else if (!rows_q[2]) low_row = 2'd2;
    else                 low_row = 2'd3;
  end

  assign sample = (div_cnt == DIV_LAST);
  assign cols   = ~(4'b0001 << col);

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_code = 4'd1;   4'h1: key_code = 4'd2;
      4'h2: key_code = 4'd3;   4'h3: key_code = 4'd12;
      4'h4: key_code = 4'd4;   4'h5: key_code = 4'd5;
      4'h6: key_code = 4'd6;   4'h7: key_code = 4'd13;
      4'h8: key_code = 4'd7;   4'h9: key_code = 4'd8;
      4'hA: key_code = 4'd9;   4'hB: key_code = 4'd14;
      4'hC: key_code = 4'd11;  4'hD: key_code = 4'd0;
      4'hE: key_code = 4'd10;  default: key_code = 4'd15;
    endcase
  endfunction

  // Column divider, scan/debounce FSM and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_SCAN;
      col        <= 2'd0;
      rec_row    <= 2'd0;
      div_cnt    <= '0;
      match_cnt  <= '0;
      rel_cnt    <= '0;
      readKey    <= 1'b0;
      pressedkey <= '0;
    end else begin
      div_cnt <= sample ? '0 : div_cnt + DIV_W'(1);
      case (state)
        S_SCAN: begin
          if (sample) begin
            if (!any_low) begin
              col <= col + 2'd1;
            end else begin
              rec_row   <= low_row;
              match_cnt <= CNT_ONE;
              // A single required sample accepts the key on detection itself
              if (DEBOUNCE_CNT == 1) begin
                pressedkey <= key_code(low_row, col);
                state      <= S_ASSERT;
              end else begin
                state <= S_DEBOUNCE;
              end
            end
          end
        end
        S_DEBOUNCE: begin
          if (sample) begin
            if (any_low && (low_row == rec_row)) begin
              match_cnt <= match_cnt + CNT_ONE;
              if ((match_cnt + CNT_ONE) == CNT_TGT) begin
                pressedkey <= key_code(rec_row, col);
                state      <= S_ASSERT;
              end
            end else begin
              match_cnt <= '0;
              col       <= col + 2'd1;
              state     <= S_SCAN;
            end
          end
        end
        S_ASSERT: begin
          readKey   <= 1'b1;
          match_cnt <= '0;
          rel_cnt   <= '0;
          state     <= S_HELD;
        end
        default: begin
          if (sample) begin
            if (any_low) begin
              rel_cnt <= '0;
            end else if ((rel_cnt + CNT_ONE) == CNT_TGT) begin
              rel_cnt <= '0;
              readKey <= 1'b0;
              col     <= col + 2'd1;
              state   <= S_SCAN;
            end else begin
              rel_cnt <= rel_cnt + CNT_ONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE_CNT = 3.
// A behavioural keypad pulls row r low whenever key (r,c) is down and
// column c is driven low.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        readKey;
  logic [3:0]  pressedkey;
  logic [15:0] keys_down;   // bit r*4+c
  logic [3:0]  kmap [16];
  int          tests = 0;
  int          fails = 0;
  int          pulses = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .rows       (rows),
    .cols       (cols),
    .readKey    (readKey),
    .pressedkey (pressedkey)
  );

  always #5 clk = ~clk;

  // Keypad matrix model
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys_down[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rk(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (readKey !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 8'(readKey), 8'(lvl));
  endtask

  task automatic wait_cols(input logic [3:0] v, input int budget, input string tag);
    int n = 0;
    while (cols !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 8'(cols), 8'(v));
  endtask

  initial begin
    kmap = '{4'd1, 4'd2, 4'd3, 4'd12, 4'd4, 4'd5, 4'd6, 4'd13,
             4'd7, 4'd8, 4'd9, 4'd14, 4'd11, 4'd0, 4'd10, 4'd15};
    keys_down = '0;
    reset = 1'b1;
    cyc(2);
    check("reset_cols", 8'(cols), 8'b1110);
    check("reset_readKey", 8'(readKey), 8'd0);
    check("reset_pressedkey", 8'(pressedkey), 8'd0);
    reset = 1'b0;

    // Clean press of '5' aligned to the start of column 1: detection at the
    // first sample, latch two samples later, strobe one cycle after that
    wait_cols(4'b1101, 40, "reach_col1");
    keys_down[5] = 1'b1;
    cyc(11);
    check("pk_before_latch", 8'(pressedkey), 8'd0);
    cyc(1);
    check("pk_latch_5", 8'(pressedkey), 8'd5);
    check("rk_low_at_latch", 8'(readKey), 8'd0);
    cyc(1);
    check("rk_rise", 8'(readKey), 8'd1);
    cyc(60);
    check("rk_held", 8'(readKey), 8'd1);
    check("pk_held", 8'(pressedkey), 8'd5);
    keys_down = '0;
    cyc(8);
    check("rk_release_not_early", 8'(readKey), 8'd1);
    wait_rk(1'b0, 8, "rk_release");
    check("pk_after_release", 8'(pressedkey), 8'd5);

    // Bounce on '=' (row 3, col 2): seen at one sample only
    wait_cols(4'b1110, 40, "reach_col0");
    wait_cols(4'b1011, 40, "reach_col2");
    keys_down[14] = 1'b1;
    cyc(4);
    check("bounce_col_held", 8'(cols), 8'b1011);
    keys_down = '0;
    cyc(4);
    check("bounce_next_col", 8'(cols), 8'b0111);
    check("bounce_rk", 8'(readKey), 8'd0);
    check("bounce_pk", 8'(pressedkey), 8'd5);
    cyc(20);
    check("bounce_no_strobe", 8'(readKey), 8'd0);

    // Rows 0 and 2 low on column 3: row 0 wins
    keys_down[3]  = 1'b1;
    keys_down[11] = 1'b1;
    wait_rk(1'b1, 100, "multi_press");
    check("multi_pk_12", 8'(pressedkey), 8'd12);
    keys_down = '0;
    wait_rk(1'b0, 40, "multi_release");

    // Hold '4'; swap to '7' in the same column, then add '8' in another column
    keys_down[4] = 1'b1;
    wait_rk(1'b1, 100, "press_4");
    check("pk_4", 8'(pressedkey), 8'd4);
    keys_down[8] = 1'b1;
    keys_down[4] = 1'b0;
    cyc(40);
    check("same_col_swap_rk", 8'(readKey), 8'd1);
    check("same_col_swap_pk", 8'(pressedkey), 8'd4);
    keys_down[9] = 1'b1;
    cyc(40);
    check("other_col_rk", 8'(readKey), 8'd1);
    check("other_col_pk", 8'(pressedkey), 8'd4);
    keys_down[8] = 1'b0;
    wait_rk(1'b0, 40, "release_col0");
    check("pk_kept_4", 8'(pressedkey), 8'd4);
    wait_rk(1'b1, 100, "press_8_after");
    check("pk_8", 8'(pressedkey), 8'd8);
    keys_down = '0;
    wait_rk(1'b0, 40, "release_8");

    // Full key map sweep
    for (int k = 0; k < 16; k++) begin
      keys_down = 16'(1) << k;
      wait_rk(1'b1, 100, $sformatf("sweep_press_%0d", k));
      if (readKey === 1'b1) pulses++;
      check($sformatf("sweep_code_%0d", k), 8'(pressedkey), 8'(kmap[k]));
      keys_down = '0;
      wait_rk(1'b0, 40, $sformatf("sweep_release_%0d", k));
    end
    check("sweep_pulses", 8'(pulses), 8'd16);

    // Reset while the strobe is high
    keys_down[0] = 1'b1;
    wait_rk(1'b1, 100, "press_before_reset");
    reset = 1'b1;
    cyc(1);
    check("midreset_rk", 8'(readKey), 8'd0);
    check("midreset_pk", 8'(pressedkey), 8'd0);
    check("midreset_cols", 8'(cols), 8'b1110);
    reset = 1'b0;
    keys_down = '0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
